// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory slave port between two masters.
// Master 0 is the core load/store port, master 1 a secondary requester
// such as a boot loader or DMA engine. An owner keeps the port across a
// burst. Read data returns one cycle after each read beat. A burst that
// runs to MAX_BURST beats without a last beat is released by force, and
// err_o pulses.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : on simultaneous requests, the master not served last wins
//   undefined : fixed priority, master 0 always wins
//
// state | meaning
// IDLE  | no owner; winner chosen this cycle, no grant issued
// OWN0  | master 0 owns the port, gnt0 follows req0
// OWN1  | master 1 owns the port, gnt1 follows req1
module mem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic              m0_last_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic              m1_last_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              s_en_o,
   output logic              s_we_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [DATA_W-1:0] s_wdata_o,
   input  logic [DATA_W-1:0] s_rdata_i,
   output logic              busy_o,
   output logic              err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // The counter never holds MAX_BURST itself: the beat that would get it
   // there always releases ownership and clears it.
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rv0_q, rv1_q;
   logic               err_q;
   logic               forced;
   logic               own_req, own_we, own_last;
   logic               other_req;
   state_t             other_state;
   logic               beat;
   logic               pick1;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_srv_q;   // 1: master 1 was the most recent owner

   // Master 1 wins when alone, or when both request and master 0 was served last.
   assign pick1 = m1_req_i & (~m0_req_i | ~last_srv_q);

   // Remember who was served on each entry into an ownership state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_srv_q <= 1'b1;
      end else if ((state_d != state_q) && (state_d != IDLE)) begin
         last_srv_q <= (state_d == OWN1);
      end
   end
`else
   // Master 1 wins only when master 0 is not requesting.
   assign pick1 = m1_req_i & ~m0_req_i;
`endif

   // Route the current owner's beat onto the slave side; nothing in IDLE.
   always_comb begin
      own_req     = 1'b0;
      own_we      = 1'b0;
      own_last    = 1'b0;
      other_req   = 1'b0;
      other_state = IDLE;
      s_addr_o    = '0;
      s_wdata_o   = '0;
      unique case (state_q)
         OWN0: begin
            own_req     = m0_req_i;
            own_we      = m0_we_i;
            own_last    = m0_last_i;
            other_req   = m1_req_i;
            other_state = OWN1;
            s_addr_o    = m0_addr_i;
            s_wdata_o   = m0_wdata_i;
         end
         OWN1: begin
            own_req     = m1_req_i;
            own_we      = m1_we_i;
            own_last    = m1_last_i;
            other_req   = m0_req_i;
            other_state = OWN0;
            s_addr_o    = m1_addr_i;
            s_wdata_o   = m1_wdata_i;
         end
         default: begin
            own_req = 1'b0;
         end
      endcase
   end

   // The owner is granted whenever it requests, so every owner request is a beat.
   assign beat     = own_req;
   assign m0_gnt_o = (state_q == OWN0) & m0_req_i;
   assign m1_gnt_o = (state_q == OWN1) & m1_req_i;
   assign s_we_o   = beat & own_we;
   assign s_en_o   = beat & ~own_we;

   // Next state, forced-release detection and beat counter.
   always_comb begin
      state_d = state_q;
      forced  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (m0_req_i | m1_req_i) begin
               state_d = pick1 ? OWN1 : OWN0;
            end
         end
         OWN0, OWN1: begin
            forced = beat & ~own_last & (cnt_q == CNT_W'(MAX_BURST - 1));
            if (~own_req | (beat & own_last) | forced) begin
               state_d = other_req ? other_state : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (beat) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State, counter, read-return tags and error pulse registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rv0_q   <= (state_q == OWN0) & s_en_o;
         rv1_q   <= (state_q == OWN1) & s_en_o;
         err_q   <= forced;
      end
   end

   assign m0_rvalid_o = rv0_q;
   assign m1_rvalid_o = rv1_q;
   assign m0_rdata_o  = s_rdata_i;
   assign m1_rdata_o  = s_rdata_i;
   assign busy_o      = (state_q != IDLE);
   assign err_o       = err_q;

endmodule
